// File: rtl/fetch_align.sv
// Fetch/align stage: buffers fetched words as halfwords and emits RVC or 32-bit instructions, including boundary straddlers.
// Define FETCHBUF_BYPASS_EN to present the first instruction of a word fetched into an empty buffer in the same cycle.
module fetch_align #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_rvc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FETCH_LIMIT = CW'(DEPTH - 2);
`ifdef FETCHBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [15:0]   r_fifo [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_pc;
  logic          r_skip_low;

  logic [15:0] w_h;
  logic [15:0] w_h1;
  logic        w_h_rvc;
  logic        w_reg_valid;
  logic        w_acc;
  logic [15:0] w_p0;
  logic        w_p0_rvc;
  logic        w_byp_valid;
  logic        w_take;
  logic        w_byp_take;
  logic [1:0]  w_pop_n;
  logic [1:0]  w_push_n;
  logic [15:0] w_d0;
  logic [15:0] w_d1;

  assign w_h         = r_fifo[r_head];
  assign w_h1        = r_fifo[r_head + AW'(1)];
  assign w_h_rvc     = (w_h[1:0] != 2'b11);
  assign w_reg_valid = ((r_count >= CW'(1)) && w_h_rvc) || ((r_count >= CW'(2)) && !w_h_rvc);

  assign mem_valid = reset && !flush && (r_count <= FETCH_LIMIT);
  assign mem_addr  = r_fetch_addr;
  assign w_acc     = mem_valid && mem_ready;

  // First parcel of the incoming word after dropping the low half on a mid-word redirect.
  assign w_p0        = r_skip_low ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_p0_rvc    = (w_p0[1:0] != 2'b11);
  assign w_byp_valid = BYP && (r_count == '0) && w_acc && (w_p0_rvc || !r_skip_low);

  always_comb begin
    out_valid = 1'b0;
    out_rvc   = 1'b0;
    out_instr = 32'h0;
    if (reset && !flush) begin
      if (r_count != '0) begin
        if (w_reg_valid) begin
          out_valid = 1'b1;
          out_rvc   = w_h_rvc;
          out_instr = w_h_rvc ? {16'h0, w_h} : {w_h1, w_h};
        end
      end else if (w_byp_valid) begin
        out_valid = 1'b1;
        out_rvc   = w_p0_rvc;
        out_instr = w_p0_rvc ? {16'h0, w_p0} : mem_rdata;
      end
    end
  end
  assign out_pc = r_pc;

  assign w_take     = out_valid && out_ready;
  assign w_byp_take = w_take && (r_count == '0);
  assign w_pop_n    = (w_take && !w_byp_take) ? (out_rvc ? 2'd1 : 2'd2) : 2'd0;

  always_comb begin
    w_push_n = 2'd0;
    w_d0     = mem_rdata[31:16];
    w_d1     = mem_rdata[31:16];
    if (w_acc) begin
      if (r_skip_low) begin
        w_push_n = w_byp_take ? 2'd0 : 2'd1;
      end else if (w_byp_take) begin
        w_push_n = out_rvc ? 2'd1 : 2'd0;
      end else begin
        w_push_n = 2'd2;
        w_d0     = mem_rdata[15:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_n != 2'd0) r_fifo[r_tail] <= w_d0;
    if (w_push_n == 2'd2) r_fifo[r_tail + AW'(1)] <= w_d1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_skip_low   <= RESET_PC[1];
      r_pc         <= {RESET_PC[31:1], 1'b0};
    end else if (flush) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_fetch_addr <= flush_pc & ~32'h3;
      r_skip_low   <= flush_pc[1];
      r_pc         <= flush_pc & ~32'h1;
    end else begin
      r_tail  <= r_tail + AW'(w_push_n);
      r_head  <= r_head + AW'(w_pop_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
      if (w_acc) begin
        r_fetch_addr <= r_fetch_addr + 32'd4;
        r_skip_low   <= 1'b0;
      end
      if (w_take) r_pc <= r_pc + (out_rvc ? 32'd2 : 32'd4);
    end
  end

endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Instruction fetch/alignment stage upstream of the compressed-instruction decoder.
- Fetches 32-bit words from instruction memory and buffers them as halfwords.
- Emits one aligned instruction per handshake: a 16-bit RVC parcel or a full 32-bit instruction, including 32-bit instructions that straddle a word boundary.
- Handles redirects (branch/jump/trap) to any halfword-aligned PC.

Parameters:
- DEPTH, 8, halfword FIFO entries. Power of two, ≥4.
- RESET_PC, 32'h00000000, first fetch address after reset. Halfword aligned.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_valid  out  1  fetch request valid.
- mem_addr  out  32  fetch word address; bits [1:0] always 0.
- mem_ready  in  1  request accepted. mem_rdata is valid in the same cycle.
- mem_rdata  in  32  fetched word, little-endian halfwords.
- flush  in  1  redirect strobe.
- flush_pc  in  32  redirect target; bit 0 ignored.
- out_valid  out  1  instruction available.
- out_ready  in  1  decoder accepts the instruction.
- out_instr  out  32  instruction. For RVC, [15:0] is the parcel and [31:16] is 0.
- out_pc  out  32  PC of out_instr.
- out_rvc  out  1  1 when out_instr is 16-bit (parcel bits [1:0] != 2'b11).

Behaviour:
- State:
  - halfword FIFO with head, tail, and count (0..DEPTH);
  - fetch_addr (word aligned);
  - skip_low flag;
  - pc_q.
- Reset (reset=0 at a clock edge):
  - count=0, head=tail=0;
  - fetch_addr={RESET_PC[31:2],2'b00};
  - skip_low=RESET_PC[1];
  - pc_q=RESET_PC with bit 0 cleared.
  - Outputs in the cycle after the reset edge: out_valid=0, mem_valid=0, out_instr=0, out_rvc=0, out_pc=pc_q.
  - Reset asserted mid-operation discards all buffered data and any in-flight request.
- Fetch:
  - mem_valid=1 when reset is deasserted, flush=0, and count ≤ DEPTH-2.
  - The count used is the registered value, before any same-cycle pop.
  - mem_addr=fetch_addr.
  - On mem_valid && mem_ready:
    - If skip_low=0, push mem_rdata[15:0] then mem_rdata[31:16] (2 entries).
    - If skip_low=1, push only mem_rdata[31:16] and clear skip_low.
    - fetch_addr += 4, wrapping modulo 2^32.
- Output (registered path):
  - Head parcel h = FIFO[head].
  - If count≥1 and h[1:0]!=2'b11: out_valid=1, out_rvc=1, out_instr={16'b0,h}.
  - If count≥2 and h[1:0]==2'b11: out_valid=1, out_rvc=0, out_instr={FIFO[head+1],h}.
  - Otherwise out_valid=0. This covers a 32-bit head with count==1, i.e. a straddling instruction waiting for the next word.
  - out_pc=pc_q.
  - out_instr and out_rvc are don't-care while out_valid=0, except in the post-reset cycle.
- Consume:
  - On out_valid && out_ready, pop 1 entry (RVC) or 2 entries (32-bit).
  - pc_q += 2 or 4 accordingly.
- Simultaneous push and pop in one cycle:
  - count_next = count + pushed − popped.
  - The head/tail pointers wrap modulo DEPTH.
  - Count never exceeds DEPTH by construction.
- Flush has highest priority. On a cycle with flush=1:
  - mem_valid=0 and out_valid=0 in that same cycle. Any memory response and any out handshake in that cycle are ignored.
  - Next state: count=0, fetch_addr={flush_pc[31:2],2'b00}, skip_low=flush_pc[1], pc_q={flush_pc[31:1],1'b0}.
  - Earliest out_valid is 2 cycles after flush, given mem_ready=1 on the first request.
  - Back-to-back flushes: the last one wins.
- Latency, registered path: word accepted in cycle N → out_valid in cycle N+1.
- Throughput: one instruction per cycle while the FIFO holds data and mem_ready keeps up.

Optional Feature:
- FETCHBUF_BYPASS_EN defined (bypass path):
  - Applies when count==0 and mem_valid && mem_ready.
  - The first complete instruction in the skip-adjusted incoming word is presented combinationally in the same cycle.
    - An RVC parcel at either halfword position qualifies.
    - A 32-bit instruction qualifies only when skip_low=0.
  - If out_ready=1 in that cycle, that instruction is not written to the FIFO, and only the remaining halfword (if any) is pushed.
  - If out_ready=0, the normal push occurs.
  - A 32-bit instruction starting at the upper halfword is pushed and waits for the next word.
  - Latency from word acceptance to presented instruction: 0 cycles.
  - Flush still forces out_valid=0 in its cycle.
- FETCHBUF_BYPASS_EN undefined:
  - No combinational path from mem_rdata or mem_ready to any out_* signal.
  - Latency 1 cycle as above.

Test Plan:
- Reset, then release with RESET_PC=0 and memory returning 0x00000013 (addi nop) at every address, out_ready=1.
  - Cycle after the reset edge: out_valid=0, mem_valid=0, out_pc=0.
  - Then out_valid=1 with out_pc=0,4,8,…, out_rvc=0, out_instr=0x00000013.
- Word 0x00010001 (two c.nop) at addr 0 → two RVC outputs at pc 0 and 2, each with out_instr=0x00000001.
- Straddle: word0=0x00130001 and word1=0x00010000, i.e. c.nop at 0, then addi 0x00000013 split across the boundary at 2 → outputs pc0 RVC 0x0001, then pc2 32-bit 0x00000013; the second output is held until word1 arrives.
- Backpressure: out_ready=0 for 10 cycles → mem_valid drops once count > DEPTH-2, no entry is overwritten, and draining yields the in-order PC sequence.
- Flush to 0x00000106 while fetching → next mem_addr=0x104, only halfword [31:16] is pushed, first out_pc=0x106, and stale data is never emitted, including when mem_ready=1 in the flush cycle.
- FETCHBUF_BYPASS_EN with an empty FIFO, an RVC parcel at addr 0, and out_ready=1 → out_valid=1 in the same cycle as mem_ready, and count becomes 1.
